// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops (latency 1); MULU/DIVU iterate W steps (out_valid W+1 edges after accept).
// Result held in DONE until out_ready; in_ready follows out_ready there, so back-to-back ops see no bubble.
module alu_seq #(
    parameter int W  = 32,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   alu_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_lo,
    output logic [W-1:0] out_hi,
    output logic         out_zero,
    output logic         out_ovf
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;

    localparam logic [SW-1:0] CNT_LOAD = SW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_cnt, w_cnt_nxt;
    logic          r_is_div, w_is_div_nxt;
    logic [W-1:0]  r_opnd, w_opnd_nxt;
    logic [W-1:0]  r_lo, w_lo_nxt;
    logic [W-1:0]  r_hi, w_hi_nxt;
    logic          r_zero, w_zero_nxt;
    logic          r_ovf, w_ovf_nxt;

    logic [W-1:0]  w_sum, w_diff, w_s_lo;
    logic          w_s_ovf, w_s_known;
    logic [SW-1:0] w_sh;
    logic [W:0]    w_add, w_rsh, w_trial;
    logic [W-1:0]  w_step_lo, w_step_hi;
    logic          w_load;

    // Single-cycle result, computed straight from the presented operands.
    always_comb begin
        w_sh      = in_b[SW-1:0];
        w_sum     = in_a + in_b;
        w_diff    = in_a - in_b;
        w_s_lo    = '0;
        w_s_ovf   = 1'b0;
        w_s_known = 1'b1;
        case (alu_op)
            OP_ADD: begin
                w_s_lo  = w_sum;
                w_s_ovf = (in_a[W-1] == in_b[W-1]) && (w_sum[W-1] != in_a[W-1]);
            end
            OP_SUB: begin
                w_s_lo  = w_diff;
                w_s_ovf = (in_a[W-1] != in_b[W-1]) && (w_diff[W-1] != in_a[W-1]);
            end
            OP_AND:  w_s_lo = in_a & in_b;
            OP_OR:   w_s_lo = in_a | in_b;
            OP_NOR:  w_s_lo = ~(in_a | in_b);
            OP_XOR:  w_s_lo = in_a ^ in_b;
            OP_SHL:  w_s_lo = in_a << w_sh;
            OP_SHR:  w_s_lo = in_a >> w_sh;
            OP_SRA:  w_s_lo = W'($signed(in_a) >>> w_sh);
            OP_SLT:  w_s_lo = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            default: w_s_known = 1'b0;
        endcase
    end

    // One iteration: {hi,lo} is the shift-add product register or the {rem,quot} pair.
    always_comb begin
        w_add   = {1'b0, r_hi} + {1'b0, r_opnd};
        w_rsh   = {r_hi, r_lo[W-1]};
        w_trial = w_rsh - {1'b0, r_opnd};
        if (r_is_div) begin
            if (!w_trial[W]) begin
                w_step_hi = w_trial[W-1:0];
                w_step_lo = {r_lo[W-2:0], 1'b1};
            end else begin
                w_step_hi = w_rsh[W-1:0];
                w_step_lo = {r_lo[W-2:0], 1'b0};
            end
        end else if (r_lo[0]) begin
            w_step_hi = w_add[W:1];
            w_step_lo = {w_add[0], r_lo[W-1:1]};
        end else begin
            w_step_hi = {1'b0, r_hi[W-1:1]};
            w_step_lo = {r_hi[0], r_lo[W-1:1]};
        end
    end

    assign in_ready  = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_load    = in_valid && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign out_valid = (r_state == S_DONE);
    assign out_lo    = r_lo;
    assign out_hi    = r_hi;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_opnd_nxt   = r_opnd;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_zero_nxt   = r_zero;
        w_ovf_nxt    = r_ovf;
        if (r_state == S_BUSY) begin
            w_lo_nxt  = w_step_lo;
            w_hi_nxt  = w_step_hi;
            w_cnt_nxt = r_cnt - SW'(1);
            if (r_cnt == '0) begin
                w_state_nxt = S_DONE;
                w_zero_nxt  = (w_step_lo == '0);
                w_cnt_nxt   = '0;
            end
        end else if (w_load) begin
            w_hi_nxt  = '0;
            w_ovf_nxt = 1'b0;
            w_zero_nxt = 1'b0;
            if (alu_op == OP_MULU || alu_op == OP_DIVU) begin
                w_is_div_nxt = (alu_op == OP_DIVU);
                w_lo_nxt     = (alu_op == OP_DIVU) ? in_a : in_b;
                w_opnd_nxt   = (alu_op == OP_DIVU) ? in_b : in_a;
                w_cnt_nxt    = CNT_LOAD;
                w_state_nxt  = S_BUSY;
            end else begin
                // Unknown opcodes report zero result with both flags clear.
                w_lo_nxt    = w_s_lo;
                w_zero_nxt  = w_s_known && (w_s_lo == '0);
                w_ovf_nxt   = w_s_ovf;
                w_state_nxt = S_DONE;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_opnd   <= w_opnd_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_zero   <= w_zero_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at W=32.
module tb_alu_seq;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_lo, out_hi;
    logic         out_zero, out_ovf;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_hi(out_hi),
        .out_zero(out_zero), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Monitor: every output handshake retires one scoreboard entry.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                g = '{lo: out_lo, hi: out_hi, zero: out_zero, ovf: out_ovf};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL result_unexpected: got lo=%h hi=%h z=%b v=%b with empty scoreboard",
                             out_lo, out_hi, out_zero, out_ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        failures++;
                        $display("FAIL result: got lo=%h hi=%h z=%b v=%b expected lo=%h hi=%h z=%b v=%b",
                                 g.lo, g.hi, g.zero, g.ovf, e.lo, e.hi, e.zero, e.ovf);
                    end
                end
            end
        end
    end

    // Issue one op (inputs change at posedge+1). lat counts edges from accept (inclusive) to out_valid.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit wait_done, output int lat, output bit busy_ok);
        bit rdy;
        rdy = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        in_valid = 1'b1;
        alu_op = op;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) begin
            failures++;
            $display("FAIL accept_timeout: in_ready never high for op %b", op);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        alu_op = 4'($urandom);
        if (!wait_done) return;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                       input logic z, input logic v, input int exp_lat);
        int lat;
        bit bok;
        send(op, a, b, '{lo: lo, hi: hi, zero: z, ovf: v}, 1'b1, lat, bok);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 1) chk({nm, "_busy_in_ready_low"}, 64'(bok), 64'd1);
    endtask

    initial begin
        int lat;
        bit bok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        alu_op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_lo", 64'(out_lo), 64'd0);
        chk("reset_out_hi", 64'(out_hi), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        run("add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1'b0, 1'b1, 1);
        run("sub_zero", 4'b0010, 32'd5,        32'd5,        32'h0,        0, 1'b1, 1'b0, 1);
        run("sub_ovf",  4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1'b0, 1'b1, 1);
        run("and",      4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1'b0, 1'b0, 1);
        run("or",       4'b0101, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 0, 1'b0, 1'b0, 1);
        run("nor",      4'b0110, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 1'b0, 1'b0, 1);
        run("sra",      4'b1001, 32'h80000000, 32'h00000024, 32'hF8000000, 0, 1'b0, 1'b0, 1);
        run("shr",      4'b1010, 32'h80000000, 32'h00000024, 32'h08000000, 0, 1'b0, 1'b0, 1);
        run("shl",      4'b1000, 32'h00000001, 32'h00000021, 32'h00000002, 0, 1'b0, 1'b0, 1);
        run("slt_true", 4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1'b0, 1'b0, 1);
        run("slt_false",4'b1110, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 1'b1, 1'b0, 1);
        run("bad_op",   4'b0011, 32'h00000000, 32'h00000000, 32'h00000000, 0, 1'b0, 1'b0, 1);
        run("mulu_max", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
        run("mulu_small",4'b1100,32'd3,        32'd5,        32'd15,       32'd0, 1'b0, 1'b0, 33);
        run("divu",     4'b1101, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 33);
        run("divu_zero",4'b1101, 32'h00001234, 32'h0,        32'hFFFFFFFF, 32'h00001234, 1'b0, 1'b0, 33);

        // Backpressure: hold an ADD result, then retire it while accepting an XOR.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run("bp_add", 4'b0000, 32'h10, 32'h20, 32'h30, 0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_lo", 64'(out_lo), 64'h30);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        run("bp_xor", 4'b0111, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 0, 1'b0, 1'b0, 1);

        // Reset in the middle of a divide.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        send(4'b1101, 32'd1000, 32'd3, '{lo: 32'd333, hi: 32'd1, zero: 1'b0, ovf: 1'b0}, 1'b0, lat, bok);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_lo", 64'(out_lo), 64'd0);
        chk("rst_mid_out_hi", 64'(out_hi), 64'd0);
        chk("rst_mid_flags", 64'({out_zero, out_ovf}), 64'd0);
        chk("rst_mid_in_ready_low", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready_release", 64'(in_ready), 64'd1);
        run("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 0, 1'b0, 1'b0, 1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
